usb_rx_ctrl: RTL and testbench
==============================

# usb_rx_ctrl

Packet-level controller for the USB receiver. It sequences the receiver's RX FIFO: drains bytes into the downstream endpoint buffer and classifies each completed packet by PID. It tracks the DATA0/DATA1 toggle and requests an ACK handshake from the transmit path when a data packet is accepted. It sits between `usb_receiver` (d_plus/d_minus side) and the endpoint buffer/transmitter.

## Interface
- MAX_BYTES, 64: maximum data payload bytes per packet; more is an overflow error.
- clk  in  1  system clock.
- n_rst  in  1  reset, synchronous, active-low.
- rcving  in  1  receiver packet-in-progress flag.
- r_error  in  1  receiver error flag (sync/EOP/PID/bit-stuff).
- PID  in  4  receiver PID; stable from PID byte until next SYNC.
- empty  in  1  RX FIFO empty.
- r_data  in  8  RX FIFO head byte; valid whenever empty=0 (first-word fall-through).
- r_enable  out  1  RX FIFO pop, one-cycle pulse.
- buf_full  in  1  endpoint buffer full (backpressure).
- buf_wr  out  1  endpoint buffer write strobe.
- buf_wdata  out  8  endpoint buffer write data.
- buf_clear  out  1  one-cycle pulse to discard the buffered payload.
- tx_req  out  1  handshake request to transmitter.
- tx_pid  out  4  handshake PID; 4'b0010 (ACK).
- tx_ack  in  1  transmitter accepted request, one-cycle pulse.
- pkt_valid  out  1  one-cycle pulse: rx_packet/byte_count valid.
- rx_packet  out  3  0 none, 1 OUT, 2 IN, 3 SETUP, 4 DATA ok, 5 DATA dup, 6 ACK/NAK/STALL, 7 error.
- byte_count  out  7  payload bytes written for the last packet.
- data_toggle  out  1  expected next data PID (0=DATA0, 1=DATA1).

## Operation
- States: IDLE, RCV, DRAIN, DECODE, HS_REQ, DONE.
- IDLE: byte counter cleared. rcving rise -> RCV.
- RCV: pop when empty=0 and buf_full=0. The pop asserts r_enable, buf_wr=1 and buf_wdata=r_data in the same cycle, and increments the counter. At most one pop every 2 cycles; the cycle after a pop is never a pop. rcving fall -> DRAIN.
- DRAIN: same pop rule until empty=1 -> DECODE.
- Counter saturates at MAX_BYTES+1. Writes beyond MAX_BYTES are suppressed, and a sticky overflow flag is set.
- DECODE (one cycle), evaluated in priority order:
  - r_error=1 or overflow: rx_packet=7, buf_clear -> DONE.
  - PID 0001/1001/1101: rx_packet=1/2/3. SETUP also forces data_toggle=0. Any popped bytes cause buf_clear -> DONE.
  - PID 0011/1011 with PID[3]==data_toggle: rx_packet=4, toggle flips -> HS_REQ.
  - Same PIDs with PID[3]!=data_toggle: rx_packet=5, buf_clear, toggle unchanged -> HS_REQ.
  - PID 0010/1010/1110: rx_packet=6 -> DONE.
  - Any other PID: rx_packet=7, buf_clear -> DONE.
- HS_REQ: tx_req=1 and tx_pid=0010 held until the tx_ack cycle -> DONE.
- DONE: pkt_valid=1 for one cycle. byte_count reflects the counter (includes suppressed overflow count) -> IDLE.
- rcving rise while in HS_REQ/DONE is not lost. It is latched, and the FSM enters RCV directly after DONE.
- buf_full stalls popping indefinitely. The FIFO holds bytes, and no byte is dropped or duplicated.

## Timing
- Reset (n_rst=0 at a clk edge) dominates every state. The FSM goes to IDLE. All outputs are 0 except tx_pid=0010. Counter, overflow and data_toggle are 0, and rx_packet=0.
- Reset mid-packet leaves no partial buf_wr or tx_req.
- All outputs are registered. r_enable and buf_wr are asserted in the same cycle.
- Pop latency: the first pop occurs 1 cycle after the cycle in which empty=0 is sampled in RCV/DRAIN.
- DECODE occurs 1 cycle after empty=1 is sampled in DRAIN.
- pkt_valid arrives 1 cycle after DECODE (no handshake), or 1 cycle after tx_ack.
- rx_packet and byte_count hold their values until the next DECODE.
- tx_ack while tx_req=0 is ignored.

## Test plan
- Reset: n_rst low 2 cycles mid-RCV -> all outputs 0, tx_pid=0010, data_toggle=0, no further buf_wr.
- DATA0 with 3 bytes 00,40,61, toggle=0 -> buf_wr x3 in order, tx_req until tx_ack, pkt_valid with rx_packet=4, byte_count=3, data_toggle=1.
- Repeat DATA0 with toggle=1 -> rx_packet=5, buf_clear, ACK still requested, toggle stays 1.
- OUT token 0001, then IN 1001, then SETUP 1101 (toggle was 1) -> rx_packet 1, 2, 3; no tx_req; toggle=0 after SETUP.
- r_error asserted during DATA1 -> rx_packet=7, buf_clear, no tx_req, toggle unchanged. PID 1111 -> rx_packet=7.
- DATA0 with 65 bytes and buf_full toggled mid-packet -> 64 writes, no dropped or duplicated bytes, rx_packet=7, byte_count=65.

Source files
------------

// File: rtl/usb_rx_ctrl.sv
// USB receive packet controller: drains the RX FIFO into the endpoint
// buffer, classifies each packet by PID and requests ACK handshakes.
module usb_rx_ctrl #(
    parameter int MAX_BYTES = 64
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       rcving,
    input  logic       r_error,
    input  logic [3:0] PID,
    input  logic       empty,
    input  logic [7:0] r_data,
    output logic       r_enable,
    input  logic       buf_full,
    output logic       buf_wr,
    output logic [7:0] buf_wdata,
    output logic       buf_clear,
    output logic       tx_req,
    output logic [3:0] tx_pid,
    input  logic       tx_ack,
    output logic       pkt_valid,
    output logic [2:0] rx_packet,
    output logic [6:0] byte_count,
    output logic       data_toggle
);

    localparam logic [6:0] MAXB = 7'(MAX_BYTES);
    localparam logic [3:0] ACK_PID = 4'b0010;

    typedef enum logic [2:0] {
        IDLE,
        RCV,
        DRAIN,
        DECODE,
        HS_REQ,
        DONE
    } state_t;

    state_t     state;
    state_t     state_n;
    logic       rcving_q;
    logic       rise;
    logic       pend;
    logic       ovf;
    logic       err;
    logic [6:0] cnt;
    logic       pop;
    logic [2:0] pkt_n;
    logic       clr_n;
    logic       tog_n;

    assign rise = rcving & ~rcving_q;

    // r_enable doubles as the "popped last cycle" marker
    assign pop = ((state == RCV) || (state == DRAIN)) &&
                 !empty && !buf_full && !r_enable;

    always_comb begin
        state_n = state;
        pkt_n   = 3'd0;
        clr_n   = 1'b0;
        tog_n   = data_toggle;
        unique case (state)
            IDLE: begin
                if (rise) state_n = RCV;
            end
            RCV: begin
                if (!rcving) state_n = DRAIN;
            end
            DRAIN: begin
                if (empty && !r_enable) state_n = DECODE;
            end
            DECODE: begin
                state_n = DONE;
                if (err || r_error || ovf) begin
                    pkt_n = 3'd7;
                    clr_n = 1'b1;
                end else begin
                    unique case (PID)
                        4'b0001: begin
                            pkt_n = 3'd1;
                            clr_n = (cnt != 7'd0);
                        end
                        4'b1001: begin
                            pkt_n = 3'd2;
                            clr_n = (cnt != 7'd0);
                        end
                        4'b1101: begin
                            pkt_n = 3'd3;
                            clr_n = (cnt != 7'd0);
                            tog_n = 1'b0;
                        end
                        4'b0011, 4'b1011: begin
                            state_n = HS_REQ;
                            if (PID[3] == data_toggle) begin
                                pkt_n = 3'd4;
                                tog_n = ~data_toggle;
                            end else begin
                                pkt_n = 3'd5;
                                clr_n = 1'b1;
                            end
                        end
                        4'b0010, 4'b1010, 4'b1110: begin
                            pkt_n = 3'd6;
                        end
                        default: begin
                            pkt_n = 3'd7;
                            clr_n = 1'b1;
                        end
                    endcase
                end
            end
            HS_REQ: begin
                if (tx_ack) state_n = DONE;
            end
            DONE: begin
                state_n = (pend || rise) ? RCV : IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state       <= IDLE;
            rcving_q    <= 1'b0;
            pend        <= 1'b0;
            ovf         <= 1'b0;
            err         <= 1'b0;
            cnt         <= 7'd0;
            r_enable    <= 1'b0;
            buf_wr      <= 1'b0;
            buf_wdata   <= 8'd0;
            buf_clear   <= 1'b0;
            tx_req      <= 1'b0;
            tx_pid      <= ACK_PID;
            pkt_valid   <= 1'b0;
            rx_packet   <= 3'd0;
            byte_count  <= 7'd0;
            data_toggle <= 1'b0;
        end else begin
            state       <= state_n;
            rcving_q    <= rcving;
            r_enable    <= pop;
            buf_wr      <= pop && (cnt < MAXB);
            buf_clear   <= clr_n;
            tx_req      <= (state_n == HS_REQ);
            tx_pid      <= ACK_PID;
            pkt_valid   <= (state_n == DONE);
            data_toggle <= tog_n;
            if (pop) buf_wdata <= r_data;

            // new packet starts from IDLE or straight out of DONE
            if ((state == IDLE) || (state == DONE)) begin
                cnt <= 7'd0;
                ovf <= 1'b0;
                err <= 1'b0;
            end else begin
                if (pop) begin
                    if (cnt <= MAXB) cnt <= cnt + 7'd1;
                    if (cnt >= MAXB) ovf <= 1'b1;
                end
                if (r_error) err <= 1'b1;
            end

            if (state == DONE) begin
                pend <= 1'b0;
            end else if (((state == DECODE) || (state == HS_REQ)) && rise) begin
                pend <= 1'b1;
            end

            if (state == DECODE) begin
                rx_packet  <= pkt_n;
                byte_count <= cnt;
            end
        end
    end

endmodule

// File: tb/tb_usb_rx_ctrl.sv
// Scoreboard bench for usb_rx_ctrl: FIFO model, ACK responder and a
// monitor that checks buffer writes and packet reports against queues.
module tb_usb_rx_ctrl;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       rcving = 1'b0;
    logic       r_error = 1'b0;
    logic [3:0] PID = 4'd0;
    logic       empty = 1'b1;
    logic [7:0] r_data = 8'd0;
    logic       r_enable;
    logic       buf_full = 1'b0;
    logic       buf_wr;
    logic [7:0] buf_wdata;
    logic       buf_clear;
    logic       tx_req;
    logic [3:0] tx_pid;
    logic       tx_ack = 1'b0;
    logic       pkt_valid;
    logic [2:0] rx_packet;
    logic [6:0] byte_count;
    logic       data_toggle;

    usb_rx_ctrl #(.MAX_BYTES(64)) dut (
        .clk(clk), .n_rst(n_rst), .rcving(rcving), .r_error(r_error),
        .PID(PID), .empty(empty), .r_data(r_data), .r_enable(r_enable),
        .buf_full(buf_full), .buf_wr(buf_wr), .buf_wdata(buf_wdata),
        .buf_clear(buf_clear), .tx_req(tx_req), .tx_pid(tx_pid),
        .tx_ack(tx_ack), .pkt_valid(pkt_valid), .rx_packet(rx_packet),
        .byte_count(byte_count), .data_toggle(data_toggle)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] pkt;
        logic [6:0] cnt;
        logic       tog;
        logic       clr;
        logic       hs;
    } exp_t;

    exp_t       exp_pkt[$];
    logic [7:0] exp_wr[$];
    logic [7:0] fifo[$];
    logic [7:0] pb[$];

    int checks = 0;
    int failures = 0;
    int npkt = 0;
    int cyc = 0;
    int ack_wait = 0;
    int wr_cnt = 0;
    bit ignore_wr = 0;
    bit stall_en = 0;
    bit clr_seen = 0;
    bit hs_seen = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // FIFO model: pops on r_enable, presents first-word fall-through head
    always @(negedge clk) begin
        cyc++;
        if (r_enable && fifo.size() > 0) void'(fifo.pop_front());
        empty = (fifo.size() == 0);
        r_data = empty ? 8'h00 : fifo[0];
        buf_full = stall_en && ((cyc % 7) < 3);
    end

    // transmitter accepts a request after a short delay
    always @(negedge clk) begin
        if (tx_ack) begin
            tx_ack = 1'b0;
        end else if (tx_req) begin
            if (ack_wait == 2) begin
                tx_ack = 1'b1;
                ack_wait = 0;
            end else begin
                ack_wait++;
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (buf_wr) wr_cnt++;
        if (buf_wr && !ignore_wr) begin
            if (exp_wr.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL stray_wr: got data %h expected no write", buf_wdata);
            end else begin
                chk("wr_data", buf_wdata, exp_wr.pop_front());
            end
        end
        if (buf_clear) clr_seen = 1;
        if (tx_req) begin
            hs_seen = 1;
            chk("tx_pid", tx_pid, 4'b0010);
        end
        if (pkt_valid) begin
            if (exp_pkt.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL stray_pkt: got rx_packet %0d expected none", rx_packet);
            end else begin
                e = exp_pkt.pop_front();
                chk("rx_packet", rx_packet, e.pkt);
                chk("byte_count", byte_count, e.cnt);
                chk("data_toggle", data_toggle, e.tog);
                chk("buf_clear", clr_seen, e.clr);
                chk("tx_req", hs_seen, e.hs);
            end
            clr_seen = 0;
            hs_seen = 0;
            npkt++;
        end
    end

    task automatic chk_reset(input string tag);
        chk({tag, "_r_enable"}, r_enable, 0);
        chk({tag, "_buf_wr"}, buf_wr, 0);
        chk({tag, "_buf_clear"}, buf_clear, 0);
        chk({tag, "_tx_req"}, tx_req, 0);
        chk({tag, "_tx_pid"}, tx_pid, 4'b0010);
        chk({tag, "_pkt_valid"}, pkt_valid, 0);
        chk({tag, "_rx_packet"}, rx_packet, 0);
        chk({tag, "_byte_count"}, byte_count, 0);
        chk({tag, "_data_toggle"}, data_toggle, 0);
    endtask

    task automatic send_pkt(input logic [3:0] pid, input bit rerr,
                            input bit stall, input logic [2:0] epkt,
                            input logic [6:0] ecnt, input logic etog,
                            input bit eclr, input bit ehs);
        exp_t e;
        int   start;
        e.pkt = epkt;
        e.cnt = ecnt;
        e.tog = etog;
        e.clr = eclr;
        e.hs  = ehs;
        exp_pkt.push_back(e);
        start = npkt;
        @(posedge clk);
        #1;
        for (int i = 0; i < pb.size(); i++) begin
            if (i < 64) exp_wr.push_back(pb[i]);
            fifo.push_back(pb[i]);
        end
        PID = pid;
        r_error = rerr;
        stall_en = stall;
        rcving = 1'b1;
        repeat (4) @(posedge clk);
        #1 rcving = 1'b0;
        for (int t = 0; t < 1000 && npkt == start; t++) @(posedge clk);
        if (npkt == start) begin
            checks++;
            failures++;
            $display("FAIL pkt_timeout: pid %b got no pkt_valid expected one", pid);
            void'(exp_pkt.pop_back());
        end
        #1;
        r_error = 1'b0;
        stall_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int w0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset("por");
        @(posedge clk);
        #1 n_rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // reset in the middle of a packet
        ignore_wr = 1;
        PID = 4'b0011;
        for (int i = 0; i < 6; i++) fifo.push_back(8'(8'hA0 + i));
        rcving = 1'b1;
        repeat (6) @(posedge clk);
        #1 n_rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset("midrst");
        @(posedge clk);
        #1;
        fifo.delete();
        rcving = 1'b0;
        n_rst = 1'b1;
        ignore_wr = 0;
        w0 = wr_cnt;
        repeat (6) @(posedge clk);
        #1;
        chk("wr_after_reset", wr_cnt - w0, 0);
        chk("tx_req_after_reset", tx_req, 0);

        pb = '{8'h00, 8'h40, 8'h61};
        send_pkt(4'b0011, 0, 0, 3'd4, 7'd3, 1'b1, 0, 1);
        send_pkt(4'b0011, 0, 0, 3'd5, 7'd3, 1'b1, 1, 1);

        pb = '{8'h12, 8'h34};
        send_pkt(4'b0001, 0, 0, 3'd1, 7'd2, 1'b1, 1, 0);
        pb.delete();
        send_pkt(4'b1001, 0, 0, 3'd2, 7'd0, 1'b1, 0, 0);
        pb = '{8'h56, 8'h78};
        send_pkt(4'b1101, 0, 0, 3'd3, 7'd2, 1'b0, 1, 0);

        pb = '{8'h9A, 8'hBC};
        send_pkt(4'b1011, 1, 0, 3'd7, 7'd2, 1'b0, 1, 0);
        pb.delete();
        send_pkt(4'b1111, 0, 0, 3'd7, 7'd0, 1'b0, 1, 0);
        send_pkt(4'b0010, 0, 0, 3'd6, 7'd0, 1'b0, 0, 0);

        pb.delete();
        for (int i = 0; i < 65; i++) pb.push_back(8'(i * 3 + 1));
        send_pkt(4'b0011, 0, 1, 3'd7, 7'd65, 1'b0, 1, 0);

        pb = '{8'hEE};
        send_pkt(4'b0011, 0, 1, 3'd4, 7'd1, 1'b1, 0, 1);

        repeat (4) @(posedge clk);
        chk("wr_leftover", exp_wr.size(), 0);
        chk("pkt_leftover", exp_pkt.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
